// File: rtl/host_link_controller.sv
// Host command parser, nonce capture/hand-off buffers and the MSB-first byte
// counter/mux that the transmitter drains.
module host_link_controller #(
  parameter int NONCE_BYTES = 16,
  parameter int CNT_W       = 4,
  parameter int CMD_TIMEOUT = 1000000
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     rx_new_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     nonce_found_i,
  input  logic [8*NONCE_BYTES-1:0] nonce_i,
  input  logic                     reset_ping_waiting_i,
  input  logic                     reset_nonce_waiting_i,
  input  logic                     reset_byte_counter_i,
  input  logic                     decrement_byte_counter_i,
  output logic                     send_ping_o,
  output logic                     send_nonce_o,
  output logic                     chip_enabled_o,
  output logic                     byte_counter_zero_o,
  output logic [7:0]               nonce_byte_o,
  output logic                     nonce_dropped_o
);

  localparam int TO_W = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CMD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NONCE_BYTES - 1);

  typedef enum logic {IDLE, CMD} cmd_state_e;

  cmd_state_e               state_q, state_d;
  logic [TO_W-1:0]          timeout_q, timeout_d;
  logic                     ping_waiting_q, ping_waiting_d;
  logic                     nonce_waiting_q, nonce_waiting_d;
  logic                     chip_enabled_q, chip_enabled_d;
  logic                     nonce_dropped_q, nonce_dropped_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [8*NONCE_BYTES-1:0] pending_buf_q, pending_buf_d;
  logic [8*NONCE_BYTES-1:0] send_buf_q, send_buf_d;

  logic ping_set;
  logic drop_clr;
  logic drop_set;
  logic nonce_accept;

  always_comb begin
    state_d         = state_q;
    timeout_d       = timeout_q;
    chip_enabled_d  = chip_enabled_q;
    ping_waiting_d  = ping_waiting_q;
    nonce_waiting_d = nonce_waiting_q;
    nonce_dropped_d = nonce_dropped_q;
    pending_buf_d   = pending_buf_q;
    send_buf_d      = send_buf_q;
    cnt_d           = cnt_q;
    ping_set        = 1'b0;
    drop_clr        = 1'b0;
    drop_set        = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_new_i && rx_data_i == 8'd99) begin
          state_d   = CMD;
          timeout_d = '0;
        end
      end
      CMD: begin
        if (rx_new_i) begin
          state_d = IDLE;
          case (rx_data_i)
            8'd99: begin
              state_d   = CMD;
              timeout_d = '0;
            end
            8'd112: ping_set = 1'b1;
            8'd101: begin
              chip_enabled_d = 1'b1;
              ping_set       = 1'b1;
            end
            8'd120: begin
              chip_enabled_d = 1'b0;
              ping_set       = 1'b0 | 1'b1;
            end
            8'd122: drop_clr = 1'b1;
            default: ;
          endcase
        end else if (timeout_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A command that sets the ping flag beats a same-cycle clear from the transmitter.
    if (reset_ping_waiting_i) ping_waiting_d = 1'b0;
    if (ping_set)             ping_waiting_d = 1'b1;

    nonce_accept = nonce_found_i && chip_enabled_q;
    if (reset_nonce_waiting_i) begin
      send_buf_d      = pending_buf_q;
      nonce_waiting_d = nonce_accept;
      if (nonce_accept) pending_buf_d = nonce_i;
    end else if (nonce_accept) begin
      if (!nonce_waiting_q) begin
        pending_buf_d   = nonce_i;
        nonce_waiting_d = 1'b1;
      end else begin
        drop_set = 1'b1;
      end
    end

    // A loss in the same cycle as a clear request must still be reported.
    if (drop_clr) nonce_dropped_d = 1'b0;
    if (drop_set) nonce_dropped_d = 1'b1;

    if (reset_byte_counter_i) begin
      cnt_d = CNT_LAST;
    end else if (decrement_byte_counter_i) begin
      cnt_d = (cnt_q == '0) ? CNT_LAST : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      timeout_q       <= '0;
      chip_enabled_q  <= 1'b0;
      ping_waiting_q  <= 1'b0;
      nonce_waiting_q <= 1'b0;
      nonce_dropped_q <= 1'b0;
      pending_buf_q   <= '0;
      send_buf_q      <= '0;
      cnt_q           <= CNT_LAST;
    end else begin
      state_q         <= state_d;
      timeout_q       <= timeout_d;
      chip_enabled_q  <= chip_enabled_d;
      ping_waiting_q  <= ping_waiting_d;
      nonce_waiting_q <= nonce_waiting_d;
      nonce_dropped_q <= nonce_dropped_d;
      pending_buf_q   <= pending_buf_d;
      send_buf_q      <= send_buf_d;
      cnt_q           <= cnt_d;
    end
  end

  always_comb begin
    nonce_byte_o = 8'h00;
    for (int i = 0; i < NONCE_BYTES; i++) begin
      if (cnt_q == CNT_W'(i)) nonce_byte_o = send_buf_q[8*i +: 8];
    end
  end

  assign send_ping_o         = ping_waiting_q;
  assign send_nonce_o        = nonce_waiting_q;
  assign chip_enabled_o      = chip_enabled_q;
  assign nonce_dropped_o     = nonce_dropped_q;
  assign byte_counter_zero_o = (cnt_q == '0);

endmodule

// File: tb/tb_host_link_controller.sv
// Directed bench for host_link_controller: a command-parsing vector table
// followed by hand-written timeout, nonce drain, overflow and reset sequences.
module tb_host_link_controller;

  localparam int NB = 16;
  localparam int CW = 4;
  localparam int TO = 8;

  localparam logic [8*NB-1:0] NONCE_N = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [8*NB-1:0] NONCE_A = 128'hA1A2A3A4_A5A6A7A8_A9AAABAC_ADAEAFB0;
  localparam logic [8*NB-1:0] NONCE_B = 128'hB1B2B3B4_B5B6B7B8_B9BABBBC_BDBEBFC0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_new = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          found = 1'b0;
  logic [8*NB-1:0] nonce = '0;
  logic          rst_ping = 1'b0;
  logic          rst_nonce = 1'b0;
  logic          rst_cnt = 1'b0;
  logic          dec = 1'b0;
  logic          send_ping;
  logic          send_nonce;
  logic          chip_en;
  logic          cnt_zero;
  logic [7:0]    nonce_byte;
  logic          dropped;

  int checks = 0;
  int errors = 0;

  host_link_controller #(
    .NONCE_BYTES(NB),
    .CNT_W(CW),
    .CMD_TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .rx_new_i(rx_new),
    .rx_data_i(rx_data),
    .nonce_found_i(found),
    .nonce_i(nonce),
    .reset_ping_waiting_i(rst_ping),
    .reset_nonce_waiting_i(rst_nonce),
    .reset_byte_counter_i(rst_cnt),
    .decrement_byte_counter_i(dec),
    .send_ping_o(send_ping),
    .send_nonce_o(send_nonce),
    .chip_enabled_o(chip_en),
    .byte_counter_zero_o(cnt_zero),
    .nonce_byte_o(nonce_byte),
    .nonce_dropped_o(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rx_new;
    logic [7:0]      rx_data;
    logic            found;
    logic [8*NB-1:0] nonce;
    logic            rst_ping;
    logic            rst_nonce;
    logic            rst_cnt;
    logic            dec;
  } stim_t;

  typedef struct {
    string name;
    stim_t s;
    logic  ping;
    logic  en;
  } vec_t;

  function automatic stim_t idleStim();
    stim_t s;
    s.rx_new = 1'b0; s.rx_data = 8'h00; s.found = 1'b0; s.nonce = '0;
    s.rst_ping = 1'b0; s.rst_nonce = 1'b0; s.rst_cnt = 1'b0; s.dec = 1'b0;
    return s;
  endfunction

  function automatic stim_t byteStim(input logic [7:0] b);
    stim_t s = idleStim();
    s.rx_new = 1'b1;
    s.rx_data = b;
    return s;
  endfunction

  function automatic stim_t foundStim(input logic [8*NB-1:0] n);
    stim_t s = idleStim();
    s.found = 1'b1;
    s.nonce = n;
    return s;
  endfunction

  function automatic stim_t handoffStim();
    stim_t s = idleStim();
    s.rst_nonce = 1'b1;
    s.rst_cnt = 1'b1;
    return s;
  endfunction

  function automatic vec_t mkVec(input string n, input stim_t s, input logic p, input logic e);
    vec_t v;
    v.name = n; v.s = s; v.ping = p; v.en = e;
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge consume them, then sample 1 ns later.
  task automatic applyStimulus(input stim_t s);
    rx_new = s.rx_new; rx_data = s.rx_data; found = s.found; nonce = s.nonce;
    rst_ping = s.rst_ping; rst_nonce = s.rst_nonce; rst_cnt = s.rst_cnt; dec = s.dec;
    @(posedge clk);
    #1;
    rx_new = 1'b0; found = 1'b0; rst_ping = 1'b0; rst_nonce = 1'b0; rst_cnt = 1'b0; dec = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string n, input logic p, input logic nw, input logic e,
                          input logic z, input logic d, input logic [7:0] b);
    checkOutput({n, ".send_ping"}, 8'(send_ping), 8'(p));
    checkOutput({n, ".send_nonce"}, 8'(send_nonce), 8'(nw));
    checkOutput({n, ".chip_en"}, 8'(chip_en), 8'(e));
    checkOutput({n, ".cnt_zero"}, 8'(cnt_zero), 8'(z));
    checkOutput({n, ".dropped"}, 8'(dropped), 8'(d));
    checkOutput({n, ".nonce_byte"}, nonce_byte, b);
  endtask

  vec_t tbl[16];
  stim_t s;

  initial begin
    tbl[0]  = mkVec("idle_p",      byteStim(8'd112), 1'b0, 1'b0);
    tbl[1]  = mkVec("c_en",        byteStim(8'd99),  1'b0, 1'b0);
    tbl[2]  = mkVec("e",           byteStim(8'd101), 1'b1, 1'b1);
    tbl[3]  = mkVec("rp_after_e",  idleStim(),       1'b0, 1'b1);
    tbl[4]  = mkVec("c_dis",       byteStim(8'd99),  1'b0, 1'b1);
    tbl[5]  = mkVec("x",           byteStim(8'd120), 1'b1, 1'b0);
    tbl[6]  = mkVec("rp_after_x",  idleStim(),       1'b0, 1'b0);
    tbl[7]  = mkVec("c_bad",       byteStim(8'd99),  1'b0, 1'b0);
    tbl[8]  = mkVec("bad_q",       byteStim(8'd113), 1'b0, 1'b0);
    tbl[9]  = mkVec("p_after_bad", byteStim(8'd112), 1'b0, 1'b0);
    tbl[10] = mkVec("cc_1",        byteStim(8'd99),  1'b0, 1'b0);
    tbl[11] = mkVec("cc_2",        byteStim(8'd99),  1'b0, 1'b0);
    tbl[12] = mkVec("cc_p",        byteStim(8'd112), 1'b1, 1'b0);
    tbl[13] = mkVec("c_race",      byteStim(8'd99),  1'b1, 1'b0);
    tbl[14] = mkVec("p_race_rp",   byteStim(8'd112), 1'b1, 1'b0);
    tbl[15] = mkVec("rp_final",    idleStim(),       1'b0, 1'b0);
    tbl[3].s.rst_ping  = 1'b1;
    tbl[6].s.rst_ping  = 1'b1;
    tbl[14].s.rst_ping = 1'b1;
    tbl[15].s.rst_ping = 1'b1;

    // Reset held: everything cleared, counter at NB-1 so zero flag is low.
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].s);
      checkAll(tbl[i].name, tbl[i].ping, 1'b0, tbl[i].en, 1'b0, 1'b0, 8'h00);
    end

    // Timeout: eight idle cycles abandon the command, seven do not.
    applyStimulus(byteStim(8'd99));
    repeat (TO) applyStimulus(idleStim());
    applyStimulus(byteStim(8'd112));
    checkAll("timeout_expired", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(byteStim(8'd99));
    repeat (TO - 1) applyStimulus(idleStim());
    applyStimulus(byteStim(8'd112));
    checkAll("timeout_edge", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    s = idleStim(); s.rst_ping = 1'b1;
    applyStimulus(s);

    // Nonce drain MSB first.
    applyStimulus(byteStim(8'd99));
    applyStimulus(byteStim(8'd101));
    s = idleStim(); s.rst_ping = 1'b1;
    applyStimulus(s);
    applyStimulus(foundStim(NONCE_N));
    checkAll("found_n", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(handoffStim());
    checkAll("handoff_n", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      s = idleStim(); s.dec = 1'b1;
      applyStimulus(s);
      checkAll($sformatf("drain%0d", k), 1'b0, 1'b0, 1'b1, (k == 15),
               1'b0, (k == 16) ? 8'h00 : 8'(k * 17));
    end
    s = idleStim(); s.dec = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    checkAll("dec_twice", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
    s.rst_cnt = 1'b1;
    applyStimulus(s);
    checkAll("rst_cnt_prio", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Overflow: second find while waiting is dropped, pending keeps A.
    applyStimulus(foundStim(NONCE_A));
    checkAll("found_a", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(foundStim(NONCE_B));
    checkAll("found_b_drop", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    applyStimulus(handoffStim());
    checkAll("handoff_a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1);
    s = idleStim(); s.dec = 1'b1;
    applyStimulus(s);
    checkAll("a_byte14", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA2);
    applyStimulus(byteStim(8'd99));
    checkAll("z_prefix", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA2);
    applyStimulus(byteStim(8'd122));
    checkAll("z_clear", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA2);

    // Simultaneous find and hand-off.
    applyStimulus(foundStim(NONCE_A));
    checkAll("sim_found_a", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA2);
    s = handoffStim(); s.found = 1'b1; s.nonce = NONCE_B;
    applyStimulus(s);
    checkAll("sim_handoff", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA1);
    applyStimulus(handoffStim());
    checkAll("sim_deliver_b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB1);

    // Disabled chip ignores finds.
    applyStimulus(byteStim(8'd99));
    applyStimulus(byteStim(8'd120));
    checkAll("disable", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB1);
    s = idleStim(); s.rst_ping = 1'b1;
    applyStimulus(s);
    applyStimulus(foundStim(NONCE_N));
    checkAll("found_disabled", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB1);
    applyStimulus(handoffStim());
    checkAll("handoff_disabled", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB1);

    // Asynchronous reset in the middle of a command.
    applyStimulus(byteStim(8'd99));
    applyStimulus(byteStim(8'd101));
    s = idleStim(); s.rst_ping = 1'b1;
    applyStimulus(s);
    applyStimulus(byteStim(8'd99));
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(byteStim(8'd112));
    checkAll("lone_p_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
